// File: rtl/beat_packer.sv
// beat_packer: packs RATIO narrow valid/ready beats into one registered wide beat with per-lane keep.
// Optional idle flush of a partial word is enabled by defining BEAT_PACKER_TIMEOUT_EN.
module beat_packer #(
  parameter int DATA_WD = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_WD-1:0]       data_in,
  input  logic                     last_in,
  output logic                     ready_in,
  output logic                     valid_out,
  output logic [DATA_WD*RATIO-1:0] data_out,
  output logic [RATIO-1:0]         keep_out,
  output logic                     last_out,
  input  logic                     ready_out
);

  localparam int IDX_WD = $clog2(RATIO);
  localparam logic [IDX_WD-1:0] LAST_LANE = IDX_WD'(RATIO - 1);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("beat_packer: RATIO must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [IDX_WD-1:0]                idx_reg, idx_next;
  logic                             full_reg, full_next;
  logic                             last_reg, last_next;
  logic [RATIO-1:0]                 keep_reg, keep_next;
  logic [RATIO-1:0][DATA_WD-1:0]    data_reg, data_next;

  logic fire_in;
  logic fire_out;
  logic timeout_hit;

  assign ready_in  = !full_reg || ready_out;
  assign fire_in   = valid_in && ready_in;
  assign fire_out  = full_reg && ready_out;

  assign valid_out = full_reg;
  assign data_out  = data_reg;
  assign keep_out  = keep_reg;
  assign last_out  = last_reg;

  // While full, idx is always 0, so a beat accepted alongside an output fire
  // naturally lands in lane 0 while every other lane is cleared.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    localparam logic [IDX_WD-1:0] LANE = IDX_WD'(gi);
    logic wr;
    assign wr            = fire_in && (idx_reg == LANE);
    assign data_next[gi] = wr ? data_in : (fire_out ? '0 : data_reg[gi]);
    assign keep_next[gi] = wr || (keep_reg[gi] && !fire_out);
  end

  always_comb begin
    idx_next  = idx_reg;
    full_next = full_reg;
    last_next = last_reg;
    if (fire_out) begin
      full_next = 1'b0;
      last_next = 1'b0;
    end
    if (fire_in) begin
      if (idx_reg == LAST_LANE || last_in) begin
        full_next = 1'b1;
        last_next = last_in;
        idx_next  = '0;
      end else begin
        idx_next  = idx_reg + 1'b1;
      end
    end
    if (timeout_hit) begin
      full_next = 1'b1;
      last_next = 1'b0;
      idx_next  = '0;
    end
  end

`ifdef BEAT_PACKER_TIMEOUT_EN
  localparam int CNT_WD = $clog2(TIMEOUT + 1);

  logic [CNT_WD-1:0] idle_cnt_reg, idle_cnt_next;
  logic              idle;

  // The flush fires on the idle cycle that would bring the count to TIMEOUT.
  assign idle        = (idx_reg != '0) && !full_reg && !fire_in;
  assign timeout_hit = idle && (idle_cnt_reg == CNT_WD'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (!idle || timeout_hit) begin
      idle_cnt_next = '0;
    end else begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg  <= '0;
      full_reg <= 1'b0;
      last_reg <= 1'b0;
      keep_reg <= '0;
      data_reg <= '0;
    end else begin
      idx_reg  <= idx_next;
      full_reg <= full_next;
      last_reg <= last_next;
      keep_reg <= keep_next;
      data_reg <= data_next;
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// Self-checking bench for beat_packer: vector table, reset, random scoreboard and idle-flush sequences.
module tb_beat_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  int checks   = 0;
  int failures = 0;

  beat_packer #(.DATA_WD(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ro;
    logic        ri;
    logic        vo;
    logic [31:0] dout;
    logic [3:0]  keep;
    logic        lo;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  keep;
    logic        lo;
  } word_t;

  vec_t  tbl[$];
  word_t exp_q[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic ro,
                              logic ri, logic vo, logic [31:0] dout, logic [3:0] keep, logic lo);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ro = ro;
    r.ri = ri; r.vo = vo; r.dout = dout; r.keep = keep; r.lo = lo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vo, input logic [31:0] dout,
                         input logic [3:0] keep, input logic lo);
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
    chk({tag, ".data_out"},  data_out,        dout);
    chk({tag, ".keep_out"},  32'(keep_out),  32'(keep));
    chk({tag, ".last_out"},  32'(last_out),  32'(lo));
  endtask

  // One cycle: drive at negedge, settle, then sample #1 after the rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic ro);
    @(negedge clk);
    valid_in  = v;
    data_in   = d;
    last_in   = l;
    ready_out = ro;
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] acc;
    logic [3:0]  kacc;
    int          lane;
    int          vo_seen;
    word_t       w;

    rst_n = 1'b0; valid_in = 1'b0; data_in = 8'h00; last_in = 1'b0; ready_out = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 4'h0, 1'b0);
    chk("reset.ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // v  d     l  ro | ri vo data          keep  lo
    tbl.push_back(mk(1, 8'h11, 0, 1,  1, 0, 32'h0000_0011, 4'h1, 0));
    tbl.push_back(mk(1, 8'h22, 0, 1,  1, 0, 32'h0000_2211, 4'h3, 0));
    tbl.push_back(mk(1, 8'h33, 0, 1,  1, 0, 32'h0033_2211, 4'h7, 0));
    tbl.push_back(mk(1, 8'h44, 1, 1,  1, 1, 32'h4433_2211, 4'hF, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0000, 4'h0, 0));
    tbl.push_back(mk(1, 8'hA1, 0, 1,  1, 0, 32'h0000_00A1, 4'h1, 0));
    tbl.push_back(mk(1, 8'hA2, 1, 1,  1, 1, 32'h0000_A2A1, 4'h3, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0000, 4'h0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 1,  1, 0, 32'h0000_0001, 4'h1, 0));
    tbl.push_back(mk(1, 8'h02, 0, 1,  1, 0, 32'h0000_0201, 4'h3, 0));
    tbl.push_back(mk(1, 8'h03, 0, 1,  1, 0, 32'h0003_0201, 4'h7, 0));
    tbl.push_back(mk(1, 8'h04, 0, 1,  1, 1, 32'h0403_0201, 4'hF, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'h55, 0, 0,  0, 1, 32'h0403_0201, 4'hF, 0));
    tbl.push_back(mk(1, 8'h55, 0, 1,  1, 0, 32'h0000_0055, 4'h1, 0));
    tbl.push_back(mk(1, 8'h66, 1, 1,  1, 1, 32'h0000_6655, 4'h3, 1));
    tbl.push_back(mk(1, 8'h77, 1, 1,  1, 1, 32'h0000_0077, 4'h1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0000, 4'h0, 0));
    tbl.push_back(mk(1, 8'h88, 1, 0,  1, 1, 32'h0000_0088, 4'h1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0,  0, 1, 32'h0000_0088, 4'h1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0000, 4'h0, 0));
    tbl.push_back(mk(1, 8'h99, 0, 1,  1, 0, 32'h0000_0099, 4'h1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0099, 4'h1, 0));
    tbl.push_back(mk(1, 8'hAA, 1, 1,  1, 1, 32'h0000_AA99, 4'h3, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1,  1, 0, 32'h0000_0000, 4'h0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      valid_in = tbl[i].v; data_in = tbl[i].d; last_in = tbl[i].l; ready_out = tbl[i].ro;
      #1;
      chk($sformatf("vec%0d.ready_in", i), 32'(ready_in), 32'(tbl[i].ri));
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].vo, tbl[i].dout, tbl[i].keep, tbl[i].lo);
      $display("vec %0d: v=%0b d=%h l=%0b ro=%0b -> vo=%0b data=%h keep=%b last=%0b",
               i, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ro, valid_out, data_out, keep_out, last_out);
    end

    // Reset in the middle of a packet discards the partial word.
    cycle(1, 8'hE1, 0, 1);
    cycle(1, 8'hE2, 0, 1);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'h01, 0, 1);
    cycle(1, 8'h02, 0, 1);
    cycle(1, 8'h03, 0, 1);
    cycle(1, 8'h04, 1, 1);
    chk_out("postrst", 1'b1, 32'h0403_0201, 4'hF, 1'b1);
    $display("postrst: data=%h keep=%b last=%0b", data_out, keep_out, last_out);
    cycle(0, 8'h00, 0, 1);

    // Random back-to-back traffic against a lane-accumulating scoreboard.
    acc = '0; kacc = '0; lane = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] d;
      logic       l;
      d = 8'($urandom_range(0, 255));
      l = (i == 999) ? 1'b1 : ($urandom_range(0, 4) == 0);
      acc[lane*8 +: 8] = d;
      kacc[lane] = 1'b1;
      if (lane == 3 || l) begin
        w.dout = acc; w.keep = kacc; w.lo = l;
        exp_q.push_back(w);
        acc = '0; kacc = '0; lane = 0;
      end else begin
        lane++;
      end
      @(negedge clk);
      valid_in = 1'b1; data_in = d; last_in = l; ready_out = 1'b1;
      #1;
      chk("rand.ready_in", 32'(ready_in), 32'd1);
      @(posedge clk);
      #1;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("rand.unexpected_word", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk_out("rand", 1'b1, w.dout, w.keep, w.lo);
          $display("rand word: data=%h keep=%b last=%0b", data_out, keep_out, last_out);
        end
      end
    end
    cycle(0, 8'h00, 0, 1);
    chk("rand.drain", 32'(exp_q.size()), 32'd0);
    chk("rand.idle_valid", 32'(valid_out), 32'd0);

    // Partial word followed by idle input.
    cycle(1, 8'h77, 0, 1);
`ifdef BEAT_PACKER_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      cycle(0, 8'h00, 0, 1);
      if (valid_out) n = i;
    end
    chk("timeout.cycles", 32'(n), 32'd16);
    chk_out("timeout", 1'b1, 32'h0000_0077, 4'h1, 1'b0);
    $display("timeout flush after %0d idle cycles: data=%h keep=%b last=%0b",
             n, data_out, keep_out, last_out);
    cycle(0, 8'h00, 0, 1);
    chk_out("timeout.clear", 1'b0, 32'h0, 4'h0, 1'b0);
`else
    vo_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 8'h00, 0, 1);
      if (valid_out) vo_seen++;
    end
    chk("hold.no_output", 32'(vo_seen), 32'd0);
    $display("hold: %0d output beats in 100 idle cycles", vo_seen);
    cycle(1, 8'hAB, 1, 1);
    chk_out("hold.complete", 1'b1, 32'h0000_AB77, 4'h3, 1'b1);
    cycle(0, 8'h00, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
